// File: rtl/tempo_sequencer.sv
// Tempo-scaled playback scheduler: STOP/PLAY/PAUSE control, beat prescaler and note address.
// Optional SPEED_WRAP_EN: tempo level wraps 3->1 / 1->3 instead of saturating.
module tempo_sequencer #(
  parameter int ADDR_W    = 9,
  parameter int SONG_LEN  = 512,
  parameter int BASE_DIV  = 22,
  parameter int LED_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_pause_i,
  input  logic              stop_i,
  input  logic              speed_up_i,
  input  logic              speed_down_i,
  input  logic              loop_en_i,
  output logic [ADDR_W-1:0] beat_addr_o,
  output logic              beat_tick_o,
  output logic              led_tick_o,
  output logic              song_done_o,
  output logic [1:0]        state_o,
  output logic [1:0]        speed_o
);

  // state    | meaning
  // ST_STOP  | idle, address rewound, prescaler held at 0
  // ST_PLAY  | prescaler running, beats advance
  // ST_PAUSE | prescaler and address frozen
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Prescaler wide enough for the slowest period, 2^(BASE_DIV+1).
  localparam int              CW        = BASE_DIV + 1;
  localparam logic [CW-1:0]   TC_SLOW   = {CW{1'b1}};
  localparam logic [CW-1:0]   TC_NORM   = TC_SLOW >> 1;
  localparam logic [CW-1:0]   TC_FAST   = TC_SLOW >> 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

`ifdef SPEED_WRAP_EN
  localparam logic [1:0] SPD_ABOVE_TOP = 2'd1;
  localparam logic [1:0] SPD_BELOW_BOT = 2'd3;
`else
  localparam logic [1:0] SPD_ABOVE_TOP = 2'd3;
  localparam logic [1:0] SPD_BELOW_BOT = 2'd1;
`endif

  state_e            state_q, state_d;
  logic [1:0]        speed_q, speed_d;
  logic [CW-1:0]     presc_q, presc_d, term_cnt;
  logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
  logic              tick_q, tick_d;
  logic              led_q, led_d;
  logic              done_q, done_d;
  logic              terminal, last_beat;

  always_comb begin
    case (speed_q)
      2'd1:    term_cnt = TC_SLOW;
      2'd3:    term_cnt = TC_FAST;
      default: term_cnt = TC_NORM;
    endcase
  end

  // A control strobe in the same cycle takes precedence over the beat.
  assign terminal  = (state_q == ST_PLAY) && !stop_i && !play_pause_i && (presc_q == term_cnt);
  assign last_beat = (addr_q == LAST_ADDR);
  assign next_addr = last_beat ? '0 : addr_q + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOP;
      speed_q <= 2'd2;
      presc_q <= '0;
      addr_q  <= '0;
      tick_q  <= 1'b0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      presc_q <= presc_d;
      addr_q  <= addr_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = ST_STOP;
    end else if (play_pause_i) begin
      case (state_q)
        ST_STOP:  state_d = ST_PLAY;
        ST_PLAY:  state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_PLAY;
        default:  state_d = ST_STOP;
      endcase
    end else if (terminal && last_beat && !loop_en_i) begin
      state_d = ST_STOP;
    end
  end

  always_comb begin
    speed_d = speed_q;
    if (speed_up_i && !speed_down_i) begin
      speed_d = (speed_q == 2'd3) ? SPD_ABOVE_TOP : speed_q + 2'd1;
    end else if (speed_down_i && !speed_up_i) begin
      speed_d = (speed_q == 2'd1) ? SPD_BELOW_BOT : speed_q - 2'd1;
    end
  end

  always_comb begin
    presc_d = presc_q;
    addr_d  = addr_q;
    tick_d  = 1'b0;
    led_d   = 1'b0;
    done_d  = 1'b0;
    if (stop_i) begin
      presc_d = '0;
      addr_d  = '0;
    end else if (terminal) begin
      presc_d = '0;
      addr_d  = next_addr;
      tick_d  = 1'b1;
      led_d   = (next_addr[LED_SHIFT-1:0] == '0);
      done_d  = last_beat && !loop_en_i;
    end else if ((state_q == ST_PLAY) && !play_pause_i) begin
      presc_d = presc_q + CW'(1);
    end
    // Any real tempo change restarts the current beat period.
    if (speed_d != speed_q) presc_d = '0;
  end

  assign beat_addr_o = addr_q;
  assign beat_tick_o = tick_q;
  assign led_tick_o  = led_q;
  assign song_done_o = done_q;
  assign state_o     = state_q;
  assign speed_o     = speed_q;

endmodule

// File: tb/tb_tempo_sequencer.sv
// Self-checking bench for tempo_sequencer: directed scenarios plus random strobes
// compared every cycle against a beat-counting reference model.
module tb_tempo_sequencer;
  localparam int ADDR_W    = 3;
  localparam int SONG_LEN  = 8;
  localparam int BASE_DIV  = 4;
  localparam int LED_SHIFT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              pp, st, up, dn, loop_en;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_tick, led_tick, song_done;
  logic [1:0]        state, speed;

  int checks   = 0;
  int failures = 0;

  // Reference model: elapsed cycles in the current beat, plus player status.
  int m_state, m_speed, m_addr, m_cnt;
  int m_tick, m_led, m_done;

  always #5 clk = ~clk;

  tempo_sequencer #(
    .ADDR_W(ADDR_W), .SONG_LEN(SONG_LEN), .BASE_DIV(BASE_DIV), .LED_SHIFT(LED_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .play_pause_i(pp), .stop_i(st), .speed_up_i(up), .speed_down_i(dn), .loop_en_i(loop_en),
    .beat_addr_o(beat_addr), .beat_tick_o(beat_tick), .led_tick_o(led_tick),
    .song_done_o(song_done), .state_o(state), .speed_o(speed)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_speed = 2; m_addr = 0; m_cnt = 0;
    m_tick = 0; m_led = 0; m_done = 0;
  endtask

  task automatic model_step(input bit ipp, input bit ist, input bit iup, input bit idn, input bit iloop);
    int period, nspd;
    period = 1 << (BASE_DIV + 2 - m_speed);
    m_tick = 0; m_led = 0; m_done = 0;
    if (ist) begin
      m_state = 0; m_addr = 0; m_cnt = 0;
    end else if (ipp) begin
      m_state = (m_state == 1) ? 2 : 1;
    end else if (m_state == 1) begin
      m_cnt++;
      if (m_cnt == period) begin
        m_cnt  = 0;
        m_addr = (m_addr + 1) % SONG_LEN;
        m_tick = 1;
        m_led  = ((m_addr % (1 << LED_SHIFT)) == 0) ? 1 : 0;
        if (m_addr == 0 && !iloop) begin
          m_state = 0;
          m_done  = 1;
        end
      end
    end
    nspd = m_speed + int'(iup && !idn) - int'(idn && !iup);
`ifdef SPEED_WRAP_EN
    if (nspd > 3) nspd = 1;
    if (nspd < 1) nspd = 3;
`else
    if (nspd > 3) nspd = 3;
    if (nspd < 1) nspd = 1;
`endif
    if (nspd != m_speed) begin
      m_speed = nspd;
      m_cnt   = 0;
    end
  endtask

  task automatic compare_all();
    check("state", state, m_state);
    check("speed", speed, m_speed);
    check("beat_addr", beat_addr, m_addr);
    check("beat_tick", beat_tick, m_tick);
    check("led_tick", led_tick, m_led);
    check("song_done", song_done, m_done);
  endtask

  // One clock: drive strobes, let the edge happen, check 1 time unit later.
  task automatic cyc(input bit ipp = 0, input bit ist = 0, input bit iup = 0, input bit idn = 0);
    pp = ipp; st = ist; up = iup; dn = idn;
    @(posedge clk);
    #1;
    model_step(ipp, ist, iup, idn, loop_en);
    compare_all();
    pp = 0; st = 0; up = 0; dn = 0;
  endtask

  task automatic run_until_tick(output int n, input int bound);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      cyc();
      if (beat_tick) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, ticks;
    rst = 1'b1; pp = 0; st = 0; up = 0; dn = 0; loop_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    compare_all();

    // Normal speed: beats every 16 cycles, led on even addresses
    cyc(1);
    check("play_entry", state, 1);
    run_until_tick(n, 100);
    check("tick1_lat", n, 16);
    check("tick1_addr", beat_addr, 1);
    check("tick1_led", led_tick, 0);
    run_until_tick(n, 100);
    check("tick2_lat", n, 16);
    check("tick2_led", led_tick, 1);
    run_until_tick(n, 100);
    check("tick3_lat", n, 16);
    check("tick3_addr", beat_addr, 3);
    cyc(0, 1);

    // Fast speed and the saturating/wrapping second speed_up
    cyc(0, 0, 1);
    check("speed_fast", speed, 3);
    cyc(1);
    run_until_tick(n, 100);
    check("fast_lat", n, 8);
    repeat (3) cyc();
    cyc(0, 0, 1);
`ifdef SPEED_WRAP_EN
    check("speed_wrap", speed, 1);
    run_until_tick(n, 100);
    check("after_wrap_lat", n, 32);
`else
    check("speed_sat", speed, 3);
    run_until_tick(n, 100);
    check("after_sat_lat", n, 4);
`endif
    cyc(0, 1);
    while (m_speed != 2) cyc(0, 0, m_speed < 2, m_speed > 2);

    // Pause keeps the prescaler count
    cyc(1);
    repeat (10) cyc();
    cyc(1);
    check("paused", state, 2);
    repeat (100) cyc();
    check("pause_addr", beat_addr, 0);
    cyc(1);
    run_until_tick(n, 100);
    check("resume_lat", n, 6);
    cyc(0, 1);

    // End of song without and with looping
    cyc(0, 0, 1);
    loop_en = 0;
    cyc(1);
    for (int b = 0; b < 8; b++) run_until_tick(n, 40);
    check("eos_state", state, 0);
    check("eos_done", song_done, 1);
    check("eos_addr", beat_addr, 0);
    check("eos_led", led_tick, 1);
    cyc();
    check("eos_done_pulse", song_done, 0);
    loop_en = 1;
    cyc(1);
    for (int b = 0; b < 8; b++) run_until_tick(n, 40);
    check("loop_state", state, 1);
    check("loop_done", song_done, 0);
    check("loop_addr", beat_addr, 0);

    // stop beats play_pause; up+down together cancel
    for (int b = 0; b < 8 && beat_addr != 5; b++) run_until_tick(n, 40);
    check("at_addr5", beat_addr, 5);
    cyc(1, 1);
    check("stop_pp_state", state, 0);
    check("stop_pp_addr", beat_addr, 0);
    check("stop_pp_tick", beat_tick, 0);
    cyc(0, 0, 1, 1);
    check("updown_speed", speed, 3);

    // Asynchronous reset in the middle of a beat
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("speed_slow", speed, 1);
    cyc(1);
    for (int b = 0; b < 4 && beat_addr != 3; b++) run_until_tick(n, 100);
    check("at_addr3", beat_addr, 3);
    repeat (9) cyc();
    #2 rst = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_speed", speed, 2);
    check("arst_addr", beat_addr, 0);
    check("arst_tick", beat_tick, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    compare_all();
    ticks = 0;
    repeat (40) begin
      cyc();
      if (beat_tick) ticks++;
    end
    check("post_rst_ticks", ticks, 0);

    // Random strobes against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
